rf_seq: RTL and testbench

RF_SEQ -- requirements
Module: rf_seq

---
 rtl/rf_seq_pkg.sv | 72 +++++++
 rtl/rf_seq_alu.sv | 45 ++++
 rtl/rf_seq.sv | 117 +++++++++++
 tb/tb_rf_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the register-file sequencer.
//   - fixed data/address/instruction widths
//   - opcode constants and FSM state encoding
//   - instruction field positions and field-extraction helpers
//   - opcode classification helpers used by the sequencer
package rf_seq_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  // Opcodes; anything above OP_HALT is undefined
  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W-1:0] OP_AND  = 4'd3;
  localparam logic [OP_W-1:0] OP_OR   = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_MOV  = 4'd6;
  localparam logic [OP_W-1:0] OP_LDI  = 4'd7;
  localparam logic [OP_W-1:0] OP_HALT = 4'd8;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] i);
    return i[OP_LSB +: OP_W];
  endfunction

  function automatic logic [ADDR_W-1:0] rd_of(input logic [INSTR_W-1:0] i);
    return i[RD_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] rs1_of(input logic [INSTR_W-1:0] i);
    return i[RS1_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] rs2_of(input logic [INSTR_W-1:0] i);
    return i[RS2_LSB +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] imm_of(input logic [INSTR_W-1:0] i);
    return i[IMM_LSB +: DATA_W];
  endfunction

  // Ops 1-7 write a register and update flags
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op < OP_HALT);
  endfunction

  // ADD/SUB/AND/OR/XOR drive the carry flag; MOV/LDI leave it alone
  function automatic logic op_sets_cf(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_HALT;
  endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// alu8: combinational datapath of the sequencer.
//   op     : opcode of the latched instruction
//   a, b   : register operands (rs1, rs2)
//   imm    : immediate for LDI
//   result : 8-bit result, mod 256
//   carry  : ADD carry-out, SUB borrow (a < b), 0 otherwise
module alu8
  import rf_seq_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        // Bit 8 of a 9-bit difference is set exactly when a < b
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_seq.sv
// rf_seq: multi-cycle sequencer driving an external register file.
//   clk, rst             : clock, asynchronous active-high reset
//   instr_valid, instr   : instruction offer; accepted in IDLE
//   instr_ready          : high only in IDLE
//   radda, raddb, ra, rb : register-file read port (async read data)
//   w, wadd, wdata       : register-file write port, one-cycle pulse in WB
//   zf, cf               : zero / carry flags
//   done                 : one-cycle retire pulse
//   halted               : high in HALT until reset
//   illegal              : sticky undefined-opcode flag
// Flow: IDLE -> READ -> EXEC -> WB -> IDLE (one instruction per 4 cycles).
module rf_seq
  import rf_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  radda,
  output logic [ADDR_W-1:0]  raddb,
  input  logic [DATA_W-1:0]  ra,
  input  logic [DATA_W-1:0]  rb,
  output logic               w,
  output logic [ADDR_W-1:0]  wadd,
  output logic [DATA_W-1:0]  wdata,
  output logic               zf,
  output logic               cf,
  output logic               done,
  output logic               halted,
  output logic               illegal
);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [INSTR_W-1:0] instr_p0;
  logic [DATA_W-1:0]  res_p1;
  logic               cy_p1;
  logic               ill_q;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_cy;
  logic [OP_W-1:0]    op;
  logic               rd_phase;

  assign op = op_of(instr_p0);

  alu8 u_alu (
    .op     (op),
    .a      (ra),
    .b      (rb),
    .imm    (imm_of(instr_p0)),
    .result (alu_res),
    .carry  (alu_cy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (instr_valid) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (op_writes(op))      state_nxt = ST_WB;
        else if (op == OP_HALT) state_nxt = ST_HALT;
        else                    state_nxt = ST_IDLE;
      end
      ST_WB:   state_nxt = ST_IDLE;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control: state, flags, sticky illegal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      zf    <= 1'b0;
      cf    <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_WB) begin
        zf <= (res_p1 == '0);
        if (op_sets_cf(op)) cf <= cy_p1;
      end
      if (state == ST_EXEC && op_illegal(op)) ill_q <= 1'b1;
    end
  end

  // Stage p0: instruction latched on acceptance
  always_ff @(posedge clk) begin
    if (instr_ready && instr_valid) instr_p0 <= instr;
  end

  // Stage p1: ALU result and carry captured at the end of EXEC
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      res_p1 <= alu_res;
      cy_p1  <= alu_cy;
    end
  end

  // Read addresses stay up through EXEC because the async read data
  // feeding the ALU is only captured at the end of EXEC.
  assign rd_phase    = (state == ST_READ) || (state == ST_EXEC);
  assign radda       = rd_phase ? rs1_of(instr_p0) : '0;
  assign raddb       = rd_phase ? rs2_of(instr_p0) : '0;

  // Write port and status decode straight from state so reset drops them at once
  assign instr_ready = (state == ST_IDLE);
  assign w           = (state == ST_WB);
  assign wadd        = w ? rd_of(instr_p0) : '0;
  assign wdata       = w ? res_p1 : '0;
  assign done        = w || (state == ST_EXEC && !op_writes(op));
  assign halted      = (state == ST_HALT);
  assign illegal     = ill_q || (state == ST_EXEC && op_illegal(op));

endmodule

// File: tb/tb_rf_seq.sv
module tb_rf_seq;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  radda, raddb;
  logic [7:0]  ra, rb;
  logic        w;
  logic [2:0]  wadd;
  logic [7:0]  wdata;
  logic        zf, cf, done, halted, illegal;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] rf [8] = '{default: 8'h00};

  rf_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .radda       (radda),
    .raddb       (raddb),
    .ra          (ra),
    .rb          (rb),
    .w           (w),
    .wadd        (wadd),
    .wdata       (wdata),
    .zf          (zf),
    .cf          (cf),
    .done        (done),
    .halted      (halted),
    .illegal     (illegal)
  );

  // External register file: async read, synchronous write
  assign ra = rf[radda];
  assign rb = rf[raddb];
  always @(posedge clk) if (w) rf[wadd] <= wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'd7, rd, 1'b0, imm};
  endfunction

  // Offer one instruction and follow it cycle by cycle to retirement.
  // A distractor LDI stays offered while busy and must be ignored.
  task automatic run_op(input string nm, input logic [15:0] ins, input logic exp_wr,
                        input logic [2:0] exp_wadd, input logic [7:0] exp_wdata,
                        input logic exp_zf, input logic exp_cf);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    #1 chk({nm, ".ready"}, 16'(instr_ready), 16'd1);
    @(posedge clk); #1;
    instr = 16'h7EAA;
    chk({nm, ".busy"}, 16'(instr_ready), 16'd0);
    chk({nm, ".radda"}, 16'(radda), 16'(ins[8:6]));
    chk({nm, ".raddb"}, 16'(raddb), 16'(ins[5:3]));
    chk({nm, ".w_rd"}, 16'(w), 16'd0);
    @(posedge clk); #1;
    chk({nm, ".w_ex"}, 16'(w), 16'd0);
    chk({nm, ".done_ex"}, 16'(done), 16'(!exp_wr));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({nm, ".w_wb"}, 16'(w), 16'(exp_wr));
    chk({nm, ".done_wb"}, 16'(done), 16'(exp_wr));
    if (exp_wr) begin
      chk({nm, ".wadd"}, 16'(wadd), 16'(exp_wadd));
      chk({nm, ".wdata"}, 16'(wdata), 16'(exp_wdata));
    end
    @(posedge clk); #1;
    chk({nm, ".w_after"}, 16'(w), 16'd0);
    chk({nm, ".done_after"}, 16'(done), 16'd0);
    chk({nm, ".zf"}, 16'(zf), 16'(exp_zf));
    chk({nm, ".cf"}, 16'(cf), 16'(exp_cf));
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #12;
    chk("rst.ready", 16'(instr_ready), 16'd1);
    chk("rst.w", 16'(w), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.halted", 16'(halted), 16'd0);
    chk("rst.illegal", 16'(illegal), 16'd0);
    chk("rst.flags", 16'({zf, cf}), 16'd0);
    chk("rst.addrs", 16'({radda, raddb, wadd}), 16'd0);
    chk("rst.wdata", 16'(wdata), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("ldi_r1", ldi(3'd1, 8'h05), 1'b1, 3'd1, 8'h05, 1'b0, 1'b0);
    run_op("ldi_r2", ldi(3'd2, 8'h03), 1'b1, 3'd2, 8'h03, 1'b0, 1'b0);
    run_op("add_r3", rr(4'd1, 3'd3, 3'd1, 3'd2), 1'b1, 3'd3, 8'h08, 1'b0, 1'b0);
    run_op("sub_r4", rr(4'd2, 3'd4, 3'd2, 3'd1), 1'b1, 3'd4, 8'hFE, 1'b0, 1'b1);
    run_op("ldi_r5", ldi(3'd5, 8'hFF), 1'b1, 3'd5, 8'hFF, 1'b0, 1'b1);
    run_op("ldi_r6", ldi(3'd6, 8'h01), 1'b1, 3'd6, 8'h01, 1'b0, 1'b1);
    run_op("add_r7", rr(4'd1, 3'd7, 3'd5, 3'd6), 1'b1, 3'd7, 8'h00, 1'b1, 1'b1);
    run_op("mov_r0", rr(4'd6, 3'd0, 3'd7, 3'd0), 1'b1, 3'd0, 8'h00, 1'b1, 1'b1);
    run_op("and_r1", rr(4'd3, 3'd1, 3'd1, 3'd2), 1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    run_op("sub_same", rr(4'd2, 3'd2, 3'd2, 3'd2), 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    run_op("nop", 16'h0000, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    chk("nop.illegal", 16'(illegal), 16'd0);
    run_op("ill_b", 16'hB123, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    chk("ill.sticky0", 16'(illegal), 16'd1);
    run_op("or_r3", rr(4'd4, 3'd3, 3'd1, 3'd4), 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0);
    run_op("xor_r5", rr(4'd5, 3'd5, 3'd3, 3'd1), 1'b1, 3'd5, 8'hFE, 1'b0, 1'b0);
    chk("ill.sticky1", 16'(illegal), 16'd1);
    chk("rf.r4", 16'(rf[4]), 16'h00FE);

    // ADD r1,r1,r3 = 0x01+0xFF, abandoned by reset in its WB cycle
    @(negedge clk);
    instr = rr(4'd1, 3'd1, 3'd1, 3'd3);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstwb.w_before", 16'(w), 16'd1);
    chk("rstwb.wdata_before", 16'(wdata), 16'h0000);
    rst = 1'b1;
    #1;
    chk("rstwb.w", 16'(w), 16'd0);
    chk("rstwb.done", 16'(done), 16'd0);
    chk("rstwb.wadd", 16'(wadd), 16'd0);
    chk("rstwb.ready", 16'(instr_ready), 16'd1);
    chk("rstwb.illegal", 16'(illegal), 16'd0);
    @(posedge clk); #1;
    chk("rstwb.rf_r1", 16'(rf[1]), 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    run_op("post_rst", ldi(3'd2, 8'h5A), 1'b1, 3'd2, 8'h5A, 1'b0, 1'b0);

    run_op("halt", 16'h8000, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    instr = ldi(3'd3, 8'h11);
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("halt.halted", 16'(halted), 16'd1);
      chk("halt.ready", 16'(instr_ready), 16'd0);
      chk("halt.w", 16'(w), 16'd0);
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt.rst_halted", 16'(halted), 16'd0);
    chk("halt.rst_ready", 16'(instr_ready), 16'd1);
    chk("halt.rf_r3", 16'(rf[3]), 16'h00FF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
